// File: rtl/demux_1x8_reg.sv
// Registered 1-to-8 bit demultiplexer / deserializer.
// Rebuilds a parallel word from a serial stream, one bit per load strobe.
// Lane index {sel2,sel1,sel0} = 0..7 maps to a..h. This matches the 8x1 mux select order.
module demux_1x8_reg #(
  parameter int FRAME_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       load,
  input  logic       din,
  input  logic       sel_mode,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       sel2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       frame_valid,
  output logic       err,
  output logic       busy,
  output logic [2:0] idx
);

  // Last legal lane, and the frame length widened so it can hold 8.
  localparam logic [2:0] LAST_LANE = 3'(FRAME_LEN - 1);
  localparam logic [3:0] FLEN_W    = 4'(FRAME_LEN);

  logic [7:0] lanes_q, lanes_d;
  logic [2:0] idx_q, idx_d;
  logic       fv_q, fv_d;
  logic       err_q, err_d;
  logic [2:0] ext_sel;

  assign ext_sel = {sel2, sel1, sel0};

  // Work out the next lane contents, the next index and the single-cycle flags.
  always_comb begin
    lanes_d = lanes_q;
    idx_d   = idx_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (!enable) begin
      if (sel_mode) begin
        // External mode drops any partial auto frame.
        // Lane contents are kept.
        idx_d = 3'd0;
        if (load) begin
          if ({1'b0, ext_sel} < FLEN_W) begin
            lanes_d[ext_sel] = din;
            fv_d             = (ext_sel == LAST_LANE);
          end else begin
            err_d = 1'b1;
          end
        end
      end else if (load) begin
        lanes_d[idx_q] = din;
        if (idx_q == LAST_LANE) begin
          idx_d = 3'd0;
          fv_d  = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
    end
  end

  // State registers. The synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lanes_q <= 8'd0;
      idx_q   <= 3'd0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      idx_q   <= idx_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign a           = lanes_q[0];
  assign b           = lanes_q[1];
  assign c           = lanes_q[2];
  assign d           = lanes_q[3];
  assign e           = lanes_q[4];
  assign f           = lanes_q[5];
  assign g           = lanes_q[6];
  assign h           = lanes_q[7];
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign idx         = idx_q;
  assign busy        = (idx_q != 3'd0);

endmodule

// File: tb/tb_demux_1x8_reg.sv
// Directed self-checking bench for demux_1x8_reg.
// A second instance runs with FRAME_LEN=6 to cover the short-frame and error boundary.
module tb_demux_1x8_reg;

  logic clk = 1'b0;
  logic rst_n, enable, load, din, sel_mode, sel0, sel1, sel2;
  logic a, b, c, d, e, f, g, h, frame_valid, err, busy;
  logic [2:0] idx;
  logic a6, b6, c6, d6, e6, f6, g6, h6, fv6, err6, busy6;
  logic [2:0] idx6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Lane vector printed in a..h order, so a is the MSB.
  wire [7:0] lanes  = {a, b, c, d, e, f, g, h};
  wire [7:0] lanes6 = {a6, b6, c6, d6, e6, f6, g6, h6};

  demux_1x8_reg #(.FRAME_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .din(din),
    .sel_mode(sel_mode), .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .frame_valid(frame_valid), .err(err), .busy(busy), .idx(idx)
  );

  demux_1x8_reg #(.FRAME_LEN(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .din(din),
    .sel_mode(sel_mode), .sel0(sel0), .sel1(sel1), .sel2(sel2),
    .a(a6), .b(b6), .c(c6), .d(d6), .e(e6), .f(f6), .g(g6), .h(h6),
    .frame_valid(fv6), .err(err6), .busy(busy6), .idx(idx6)
  );

  // Advance one clock, then sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset both instances and return to idle auto mode.
  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; din = 1'b0;
    sel_mode = 1'b0; {sel2, sel1, sel0} = 3'b000;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; load = 1'b1; din = 1'b1;
    sel_mode = 1'b0; {sel2, sel1, sel0} = 3'b000;
    step();
    step();
    n_checks++;
    if (lanes !== 8'h00 || idx !== 3'd0 || frame_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: lanes=%b idx=%0d fv=%b busy=%b err=%b, required 00000000/0/0/0/0",
               lanes, idx, frame_valid, busy, err);
    end else $display("reset ok: lanes=%b idx=%0d", lanes, idx);
    rst_n = 1'b1; load = 1'b0;
  endtask

  task automatic test_auto_frame();
    logic [7:0] pat;
    pat = 8'b10110010;
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; din = pat[7-i];
      step();
      n_checks++;
      if (frame_valid !== (i == 7)) begin
        n_fail++;
        $display("FAIL auto_fv load %0d: fv=%b required %b", i, frame_valid, (i == 7));
      end else $display("auto load %0d din=%b fv=%b idx=%0d", i, din, frame_valid, idx);
    end
    n_checks++;
    if (lanes !== pat || idx !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_word: lanes=%b idx=%0d busy=%b, required %b/0/0", lanes, idx, busy, pat);
    end else $display("auto word lanes=%b", lanes);
    load = 1'b0;
    step();
    n_checks++;
    if (frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_fv_width: fv=%b required 0", frame_valid);
    end else $display("auto fv dropped after one cycle");
  endtask

  task automatic test_enable_freeze();
    logic [2:0] bits3;
    int pulses;
    do_reset();
    bits3 = 3'b110;
    for (int i = 0; i < 3; i++) begin
      load = 1'b1; din = bits3[2-i];
      step();
    end
    n_checks++;
    if (lanes !== 8'b11000000 || idx !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_pre: lanes=%b idx=%0d busy=%b, required 11000000/3/1", lanes, idx, busy);
    end else $display("freeze pre lanes=%b idx=%0d", lanes, idx);
    enable = 1'b1; load = 1'b1; din = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (lanes !== 8'b11000000 || idx !== 3'd3 || frame_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold %0d: lanes=%b idx=%0d fv=%b, required 11000000/3/0",
                 i, lanes, idx, frame_valid);
      end else $display("freeze hold %0d lanes=%b idx=%0d", i, lanes, idx);
    end
    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; din = 1'b1;
      step();
      if (frame_valid === 1'b1) pulses++;
    end
    load = 1'b0;
    step();
    if (frame_valid === 1'b1) pulses++;
    n_checks++;
    if (pulses != 1 || lanes !== 8'b11011111 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL freeze_resume: pulses=%0d lanes=%b idx=%0d, required 1/11011111/0", pulses, lanes, idx);
    end else $display("freeze resume lanes=%b pulses=%0d", lanes, pulses);
  endtask

  task automatic test_external();
    do_reset();
    sel_mode = 1'b1; load = 1'b1; din = 1'b1; {sel2, sel1, sel0} = 3'b101;
    step();
    n_checks++;
    if (lanes !== 8'b00000100 || frame_valid !== 1'b0 || err !== 1'b0 || idx !== 3'd0) begin
      n_fail++;
      $display("FAIL ext_f: lanes=%b fv=%b err=%b idx=%0d, required 00000100/0/0/0", lanes, frame_valid, err, idx);
    end else $display("ext sel=101 lanes=%b", lanes);
    // The same write lands on the last lane of the 6-lane instance.
    n_checks++;
    if (lanes6 !== 8'b00000100 || fv6 !== 1'b1 || err6 !== 1'b0) begin
      n_fail++;
      $display("FAIL ext6_last: lanes=%b fv=%b err=%b, required 00000100/1/0", lanes6, fv6, err6);
    end else $display("ext6 sel=101 lanes=%b fv=%b", lanes6, fv6);
    {sel2, sel1, sel0} = 3'b110;
    step();
    n_checks++;
    if (err6 !== 1'b1 || g6 !== 1'b0 || fv6 !== 1'b0) begin
      n_fail++;
      $display("FAIL ext6_err: err=%b g=%b fv=%b, required 1/0/0", err6, g6, fv6);
    end else $display("ext6 sel=110 err=%b g=%b", err6, g6);
    n_checks++;
    if (g !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_g: g=%b err=%b, required 1/0", g, err);
    end else $display("ext sel=110 g=%b", g);
    {sel2, sel1, sel0} = 3'b111;
    step();
    n_checks++;
    if (frame_valid !== 1'b1 || h !== 1'b1 || err6 !== 1'b1 || h6 !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_last: fv=%b h=%b err6=%b h6=%b, required 1/1/1/0", frame_valid, h, err6, h6);
    end else $display("ext sel=111 fv=%b h=%b", frame_valid, h);
    load = 1'b0;
    step();
    n_checks++;
    if (err6 !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ext_pulse: err6=%b fv=%b, required 0/0", err6, frame_valid);
    end else $display("ext pulses cleared");
    // A mode switch mid-frame drops the index and keeps the lanes.
    do_reset();
    load = 1'b1; din = 1'b1;
    step();
    step();
    sel_mode = 1'b1; load = 1'b0;
    step();
    n_checks++;
    if (idx !== 3'd0 || busy !== 1'b0 || lanes !== 8'b11000000) begin
      n_fail++;
      $display("FAIL mode_switch: idx=%0d busy=%b lanes=%b, required 0/0/11000000", idx, busy, lanes);
    end else $display("mode switch idx=%0d lanes=%b", idx, lanes);
    sel_mode = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [7:0] pat;
    int pulses;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load = 1'b1; din = 1'b1;
      step();
    end
    rst_n = 1'b0;
    step();
    n_checks++;
    if (lanes !== 8'h00 || idx !== 3'd0 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: lanes=%b idx=%0d fv=%b, required 00000000/0/0", lanes, idx, frame_valid);
    end else $display("abort lanes=%b idx=%0d", lanes, idx);
    rst_n = 1'b1;
    pat = 8'b01010101;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      load = 1'b1; din = pat[7-i];
      step();
      if (frame_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (lanes !== pat || pulses != 1 || frame_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_frame: lanes=%b pulses=%0d fv=%b, required %b/1/1", lanes, pulses, frame_valid, pat);
    end else $display("abort frame lanes=%b", lanes);
    load = 1'b0;
  endtask

  task automatic test_back_to_back();
    int nloads;
    do_reset();
    nloads = 0;
    for (int i = 0; i < 16; i++) begin
      load = (i % 2 == 0); din = 1'b1;
      step();
      if (load) nloads++;
      n_checks++;
      if (idx !== 3'(nloads % 8) || frame_valid !== (load && nloads == 8)) begin
        n_fail++;
        $display("FAIL alt cyc %0d: idx=%0d fv=%b, required %0d/%b",
                 i, idx, frame_valid, nloads % 8, (load && nloads == 8));
      end else $display("alt cyc %0d load=%b idx=%0d fv=%b", i, load, idx, frame_valid);
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_auto_frame();
    test_enable_freeze();
    test_external();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
